// File: rtl/clock_time_controller.sv
`default_nettype none
// ============================================================================
//  Module   : clock_time_controller
//  Purpose  : Time-keeping sequencer for the digital clock. Cascades the
//             sec/min/hour counters on the 1 Hz tick. A button-driven set
//             mode loads hours and minutes and drives a display blink phase.
//  Revision : 1.0  initial release
// ============================================================================
module clock_time_controller #(
   parameter int SEC_MOD  = 60,
   parameter int MIN_MOD  = 60,
   parameter int HOUR_MOD = 24
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [4:0] hour,
   output logic [1:0] mode,
   output logic       blink,
   output logic       day_pulse
);

   // Wrap points are compared for equality, so the moduli only need to fit
   // the fixed field widths.
   localparam logic [5:0] c_SEC_MAX  = 6'(SEC_MOD - 1);
   localparam logic [5:0] c_MIN_MAX  = 6'(MIN_MOD - 1);
   localparam logic [4:0] c_HOUR_MAX = 5'(HOUR_MOD - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_SET_H = 2'd1,
      ST_SET_M = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] sec_q, sec_d;
   logic [5:0] min_q, min_d;
   logic [4:0] hour_q, hour_d;
   logic       blink_q, blink_d;
   logic       day_pulse_q, day_pulse_d;
   logic       btn_mode_q;
   logic       btn_inc_q;

   logic       w_ev_mode;
   logic       w_ev_inc;
   logic [5:0] w_sec_inc;
   logic [5:0] w_min_inc;
   logic [4:0] w_hour_inc;

   // Rising-edge detection on the already-synchronous button levels.
   assign w_ev_mode = btn_mode & ~btn_mode_q;
   assign w_ev_inc  = btn_inc  & ~btn_inc_q;

   // Wrapping +1 for each field, shared by run-mode carry and set-mode edits.
   assign w_sec_inc  = (sec_q  == c_SEC_MAX)  ? 6'd0 : sec_q  + 6'd1;
   assign w_min_inc  = (min_q  == c_MIN_MAX)  ? 6'd0 : min_q  + 6'd1;
   assign w_hour_inc = (hour_q == c_HOUR_MAX) ? 5'd0 : hour_q + 5'd1;

   // Button history resets high so a button held through reset gives no edge.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         btn_mode_q <= 1'b1;
         btn_inc_q  <= 1'b1;
      end else begin
         btn_mode_q <= btn_mode;
         btn_inc_q  <= btn_inc;
      end
   end

   // State and time registers.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         sec_q       <= 6'd0;
         min_q       <= 6'd0;
         hour_q      <= 5'd0;
         blink_q     <= 1'b0;
         day_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sec_q       <= sec_d;
         min_q       <= min_d;
         hour_q      <= hour_d;
         blink_q     <= blink_d;
         day_pulse_q <= day_pulse_d;
      end
   end

   // Next-state: mode edge beats inc edge beats tick; losers are dropped.
   always_comb begin
      state_d     = state_q;
      sec_d       = sec_q;
      min_d       = min_q;
      hour_d      = hour_q;
      blink_d     = blink_q;
      day_pulse_d = 1'b0;

      if (w_ev_mode) begin
         blink_d = 1'b0;
         case (state_q)
            ST_RUN:   state_d = ST_SET_H;
            ST_SET_H: state_d = ST_SET_M;
            ST_SET_M: begin
               state_d = ST_RUN;
               sec_d   = 6'd0;
            end
            default:  state_d = ST_RUN;
         endcase
      end else begin
         case (state_q)
            ST_RUN: begin
               blink_d = 1'b0;
               if (tick) begin
                  sec_d = w_sec_inc;
                  if (sec_q == c_SEC_MAX) begin
                     min_d = w_min_inc;
                     if (min_q == c_MIN_MAX) begin
                        hour_d = w_hour_inc;
                        if (hour_q == c_HOUR_MAX) begin
                           day_pulse_d = 1'b1;
                        end
                     end
                  end
               end
            end
            ST_SET_H: begin
               if (w_ev_inc) begin
                  hour_d = w_hour_inc;
               end else if (tick) begin
                  blink_d = ~blink_q;
               end
            end
            ST_SET_M: begin
               if (w_ev_inc) begin
                  min_d = w_min_inc;
               end else if (tick) begin
                  blink_d = ~blink_q;
               end
            end
            default: begin
               state_d = ST_RUN;
               blink_d = 1'b0;
            end
         endcase
      end
   end

   assign sec       = sec_q;
   assign min       = min_q;
   assign hour      = hour_q;
   assign mode      = state_q;
   assign blink     = blink_q;
   assign day_pulse = day_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_time_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_time_controller
//  Purpose  : Directed self-checking bench for clock_time_controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_time_controller;

   logic       clk_in;
   logic       rst;
   logic       tick;
   logic       btn_mode;
   logic       btn_inc;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic [1:0] mode;
   logic       blink;
   logic       day_pulse;

   int n_vec;
   int n_err;

   clock_time_controller #(
      .SEC_MOD  (60),
      .MIN_MOD  (60),
      .HOUR_MOD (24)
   ) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .tick      (tick),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .sec       (sec),
      .min       (min),
      .hour      (hour),
      .mode      (mode),
      .blink     (blink),
      .day_pulse (day_pulse)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input int obs, input int want);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic chk_time(input string tag, input int h, input int m, input int s);
      chk({tag, ".hour"}, int'(hour), h);
      chk({tag, ".min"},  int'(min),  m);
      chk({tag, ".sec"},  int'(sec),  s);
   endtask

   // Advance one clock; return 1 ns after the rising edge.
   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic press_mode();
      btn_mode = 1'b1;
      cyc();
      btn_mode = 1'b0;
      cyc();
   endtask

   task automatic press_inc(input int n);
      for (int i = 0; i < n; i++) begin
         btn_inc = 1'b1;
         cyc();
         btn_inc = 1'b0;
         cyc();
      end
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
      end
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b0;
      tick     = 1'b0;
      btn_mode = 1'b1;
      btn_inc  = 1'b0;

      // ---- T1: reset with btn_mode held high ----
      #12;
      chk_time("t1_rst", 0, 0, 0);
      chk("t1_rst.mode", int'(mode), 0);
      chk("t1_rst.blink", int'(blink), 0);
      chk("t1_rst.day", int'(day_pulse), 0);
      #10 rst = 1'b1;                       // release at t=22, away from edges
      cyc();
      cyc();
      chk("t1_held.mode", int'(mode), 0);
      // Three ticks in RUN while the button is still held.
      do_ticks(3);
      chk_time("t1_run3", 0, 0, 3);
      chk("t1_run3.mode", int'(mode), 0);
      chk("t1_run3.blink", int'(blink), 0);
      btn_mode = 1'b0;
      cyc();
      chk("t1_low.mode", int'(mode), 0);

      // ---- T3/T4: SET_H, freeze and blink ----
      btn_mode = 1'b1;
      cyc();
      chk("t3_seth.mode", int'(mode), 1);
      btn_mode = 1'b0;
      cyc();
      do_ticks(1);
      chk("t4_b1", int'(blink), 1);
      do_ticks(1);
      chk("t4_b2", int'(blink), 0);
      do_ticks(1);
      chk("t4_b3", int'(blink), 1);
      do_ticks(1);
      chk("t4_b4", int'(blink), 0);
      chk_time("t4_frozen", 0, 0, 3);
      press_inc(25);
      chk("t3_hour25", int'(hour), 1);
      chk("t3_hour25.min", int'(min), 0);
      do_ticks(1);
      chk("t4_b5", int'(blink), 1);
      btn_mode = 1'b1;
      cyc();
      chk("t3_setm.mode", int'(mode), 2);
      chk("t4_modeclr.blink", int'(blink), 0);
      btn_mode = 1'b0;
      cyc();
      press_inc(61);
      chk("t3_min61", int'(min), 1);
      chk("t3_min61.hour", int'(hour), 1);
      chk("t3_min61.sec", int'(sec), 3);
      btn_mode = 1'b1;
      cyc();
      chk("t3_exit.mode", int'(mode), 0);
      chk_time("t3_exit", 1, 1, 0);
      btn_mode = 1'b0;
      cyc();

      // ---- T5: ev_inc ignored in RUN ----
      press_inc(1);
      chk_time("t5_run_inc", 1, 1, 0);
      chk("t5_run_inc.mode", int'(mode), 0);

      // ---- T5: collisions, and preset 23:59 for T2 ----
      press_mode();
      chk("t5_seth.mode", int'(mode), 1);
      press_inc(22);
      chk("t5_h23", int'(hour), 23);
      do_ticks(1);
      chk("t5_pre.blink", int'(blink), 1);
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      tick     = 1'b1;
      cyc();
      chk("t5_coll3.mode", int'(mode), 2);
      chk("t5_coll3.hour", int'(hour), 23);
      chk("t5_coll3.min", int'(min), 1);
      chk("t5_coll3.blink", int'(blink), 0);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      tick     = 1'b0;
      cyc();
      do_ticks(1);
      chk("t5_setm.blink", int'(blink), 1);
      btn_inc = 1'b1;
      tick    = 1'b1;
      cyc();
      chk("t5_coll2.min", int'(min), 2);
      chk("t5_coll2.blink", int'(blink), 1);
      btn_inc = 1'b0;
      tick    = 1'b0;
      cyc();
      press_inc(57);
      chk("t5_m59", int'(min), 59);
      press_inc(1);
      chk("t5_mwrap.min", int'(min), 0);
      chk("t5_mwrap.hour", int'(hour), 23);
      press_inc(59);
      press_mode();
      chk("t2_exit.mode", int'(mode), 0);
      chk_time("t2_preset", 23, 59, 0);

      // ---- T2: day rollover ----
      do_ticks(59);
      chk_time("t2_235959", 23, 59, 59);
      chk("t2_pre.day", int'(day_pulse), 0);
      do_ticks(1);
      chk_time("t2_roll", 0, 0, 0);
      chk("t2_roll.day", int'(day_pulse), 1);
      cyc();
      chk("t2_after.day", int'(day_pulse), 0);
      chk_time("t2_after", 0, 0, 0);

      // ---- T6: async reset at 12:34:56 ----
      press_mode();
      press_inc(12);
      press_mode();
      press_inc(34);
      press_mode();
      do_ticks(56);
      chk_time("t6_pre", 12, 34, 56);
      #2 rst = 1'b0;
      #1;
      chk_time("t6_async", 0, 0, 0);
      chk("t6_async.mode", int'(mode), 0);
      #1 rst = 1'b1;
      cyc();
      chk_time("t6_idle", 0, 0, 0);
      do_ticks(1);
      chk_time("t6_resume", 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
